// File: rtl/simmem_bank_delay_calc.sv
// -----------------------------------------------------------------------------
// simmem_bank_delay_calc
//
// Computes the service delay of DRAM requests in a multi-bank memory model.
// Each bank tracks its open row and one outstanding request. An accepted
// request is charged a row-hit, cold-activation or precharge+activation cost.
// It is answered once that many cycles have elapsed. Responses from banks
// that finish together are arbitrated round-robin.
//
// Ports:
//   clk_i          - clock
//   rst_i          - synchronous active-high reset
//   req_valid_i    - request valid
//   req_ready_o    - addressed bank can take a request
//   req_addr_i     - request address (bank and row are decoded from it)
//   req_id_i       - request identifier, returned with the response
//   resp_valid_o   - a bank has finished and its response is presented
//   resp_ready_i   - response consumer ready
//   resp_id_o      - identifier of the presented response (zero when idle)
//   resp_delay_o   - cost charged to the presented response (zero when idle)
// -----------------------------------------------------------------------------
module simmem_bank_delay_calc #(
    parameter int NumBanks          = 4,
    parameter int AddrWidth         = 16,
    parameter int RowBufferLenWidth = 8,
    parameter int IdWidth           = 4,
    parameter int RowHitCost        = 10,
    parameter int PrechargeCost     = 50,
    parameter int ActivationCost    = 45,
    parameter int CostWidth         = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IdWidth-1:0]   resp_id_o,
    output logic [CostWidth-1:0] resp_delay_o
);

    localparam int BankW  = $clog2(NumBanks);
    localparam int RowLsb = RowBufferLenWidth + BankW;
    localparam int RowW   = AddrWidth - RowLsb;

    localparam logic [CostWidth-1:0] CostHit  = CostWidth'(RowHitCost);
    localparam logic [CostWidth-1:0] CostCold = CostWidth'(ActivationCost + RowHitCost);
    localparam logic [CostWidth-1:0] CostMiss = CostWidth'(PrechargeCost + ActivationCost + RowHitCost);

    // Per-bank state
    logic [NumBanks-1:0]  occupied_reg;
    logic [NumBanks-1:0]  row_valid_reg;
    logic [IdWidth-1:0]   id_reg    [NumBanks];
    logic [CostWidth-1:0] cost_reg  [NumBanks];
    logic [CostWidth-1:0] count_reg [NumBanks];
    logic [RowW-1:0]      row_reg   [NumBanks];

    // Arbitration state
    logic [BankW-1:0]     last_grant_reg;
    logic                 hold_reg;       // a stalled response is being held
    logic [BankW-1:0]     hold_bank_reg;

    // Request decode
    logic [BankW-1:0]     req_bank;
    logic [RowW-1:0]      req_row;
    logic [CostWidth-1:0] req_cost;
    logic                 req_fire;

    assign req_bank = req_addr_i[RowBufferLenWidth +: BankW];
    assign req_row  = req_addr_i[AddrWidth-1:RowLsb];

    // Ready looks only at registered bank state and the address, so it never
    // forms a combinational path from the response side.
    assign req_ready_o = ~occupied_reg[req_bank];
    assign req_fire    = req_valid_i & req_ready_o;

    always_comb begin
        req_cost = CostMiss;
        if (!row_valid_reg[req_bank]) begin
            req_cost = CostCold;
        end else if (row_reg[req_bank] == req_row) begin
            req_cost = CostHit;
        end
    end

    // Response selection
    logic [NumBanks-1:0] done;
    logic [NumBanks-1:0] accept_vec;
    logic [NumBanks-1:0] grant_vec;
    logic [BankW-1:0]    rr_bank;
    logic                rr_found;
    logic [BankW-1:0]    sel_bank;
    logic                resp_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NumBanks; gi++) begin : g_bank
            assign done[gi]       = occupied_reg[gi] && (count_reg[gi] == '0);
            assign accept_vec[gi] = req_fire && (req_bank == BankW'(gi));
            assign grant_vec[gi]  = resp_fire && (sel_bank == BankW'(gi));
        end
    endgenerate

    // Lowest done bank strictly after the last grant, wrapping; the last
    // granted bank itself is examined last (offset NumBanks wraps to 0).
    always_comb begin
        rr_bank  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= NumBanks; i++) begin
            if (!rr_found && done[BankW'(last_grant_reg + BankW'(i))]) begin
                rr_bank  = BankW'(last_grant_reg + BankW'(i));
                rr_found = 1'b1;
            end
        end
    end

    // Once a response has been presented and stalled, keep presenting that
    // bank even if a higher-priority bank finishes in the meantime. A held
    // bank stays done because only its own grant or reset can clear it.
    assign sel_bank     = hold_reg ? hold_bank_reg : rr_bank;
    assign resp_valid_o = hold_reg | rr_found;
    assign resp_fire    = resp_valid_o & resp_ready_i;
    assign resp_id_o    = resp_valid_o ? id_reg[sel_bank]   : '0;
    assign resp_delay_o = resp_valid_o ? cost_reg[sel_bank] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) begin
                occupied_reg[b]  <= 1'b0;
                row_valid_reg[b] <= 1'b0;
                id_reg[b]        <= '0;
                cost_reg[b]      <= '0;
                count_reg[b]     <= '0;
                row_reg[b]       <= '0;
            end
            last_grant_reg <= BankW'(NumBanks - 1);
            hold_reg       <= 1'b0;
            hold_bank_reg  <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (accept_vec[b]) begin
                    // Counter reaches zero cost-1 cycles later, so the
                    // response appears cost cycles after the accept cycle.
                    occupied_reg[b]  <= 1'b1;
                    id_reg[b]        <= req_id_i;
                    cost_reg[b]      <= req_cost;
                    count_reg[b]     <= req_cost - CostWidth'(1);
                    row_reg[b]       <= req_row;
                    row_valid_reg[b] <= 1'b1;
                end else begin
                    if (grant_vec[b]) begin
                        occupied_reg[b] <= 1'b0;
                    end
                    if (occupied_reg[b] && (count_reg[b] != '0)) begin
                        count_reg[b] <= count_reg[b] - CostWidth'(1);
                    end
                end
            end

            if (resp_fire) begin
                last_grant_reg <= sel_bank;
            end

            if (resp_valid_o && !resp_ready_i) begin
                hold_reg      <= 1'b1;
                hold_bank_reg <= sel_bank;
            end else begin
                hold_reg      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simmem_bank_delay_calc.sv
// -----------------------------------------------------------------------------
// tb_simmem_bank_delay_calc
//
// Directed bench for simmem_bank_delay_calc with default parameters. Stimulus
// pushes expected responses (id, delay, handshake cycle) to a queue; a monitor
// pops and compares each response handshake.
// -----------------------------------------------------------------------------
module tb_simmem_bank_delay_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [3:0]  req_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_id;
    logic [7:0]  resp_delay;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] id;
        logic [7:0] delay;
        int         cyc;   // expected handshake cycle, -1 = not checked
    } exp_t;

    exp_t exp_q[$];

    simmem_bank_delay_calc dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_id_i     (req_id),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_delay_o (resp_delay)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {28'd0, resp_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("resp: cyc=%0d id=%0d delay=%0d (exp id=%0d delay=%0d cyc=%0d)",
                             cyc, resp_id, resp_delay, e.id, e.delay, e.cyc);
                    chk("resp_id", {28'd0, resp_id}, {28'd0, e.id});
                    chk("resp_delay", {24'd0, resp_delay}, {24'd0, e.delay});
                    if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
                end
            end else if (!resp_valid) begin
                chk("idle_payload", {20'd0, resp_id, resp_delay}, 32'd0);
            end
        end
    end

    // Call right after a negedge. Returns the cycle number of the accept edge.
    task automatic do_req(input logic [15:0] addr, input logic [3:0] id, output int acc);
        bit ok = 1'b0;
        acc = -1;
        req_addr  = addr;
        req_id    = id;
        req_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
        $display("req: addr=%04h id=%0d accepted_cyc=%0d", addr, id, acc);
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [7:0] delay, input int c);
        exp_t e;
        e.id = id; e.delay = delay; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int a, b;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_id     = '0;
        resp_ready = 1'b1;

        // Reset state
        do_reset();
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id", {28'd0, resp_id}, 32'd0);
        chk("rst_resp_delay", {24'd0, resp_delay}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Cold, then hit, then miss on bank 0
        @(negedge clk);
        do_req(16'h0000, 4'd3, a); push_exp(4'd3, 8'd55, a + 54); drain();
        do_req(16'h0004, 4'd4, a); push_exp(4'd4, 8'd10, a + 9);  drain();
        do_req(16'h0400, 4'd5, a); push_exp(4'd5, 8'd105, a + 104); drain();

        // Bank parallelism
        do_reset();
        do_req(16'h0000, 4'd1, a); push_exp(4'd1, 8'd55, a + 54);
        @(negedge clk);
        do_req(16'h0100, 4'd2, b); push_exp(4'd2, 8'd55, b + 54);
        chk("par_back_to_back", b, a + 1);
        drain();

        // Round-robin: last grant is bank 1; banks 2 and 1 finish together
        @(negedge clk);
        do_req(16'h0200, 4'd6, a); push_exp(4'd6, 8'd55, a + 54);
        for (int i = 0; i < 100 && cyc < a + 44; i++) @(negedge clk);
        do_req(16'h0100, 4'd7, b); push_exp(4'd7, 8'd10, a + 55);
        chk("rr_accept_cycle", b, a + 45);
        drain();

        // Backpressure on bank 0
        do_reset();
        resp_ready = 1'b0;
        do_req(16'h0000, 4'd9, a); push_exp(4'd9, 8'd55, -1);
        for (int i = 0; i < 100 && cyc < a + 54; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_id", {28'd0, resp_id}, 32'd9);
            chk("bp_delay", {24'd0, resp_delay}, 32'd55);
            req_addr = 16'h0000; #1;
            chk("bp_ready_bank0", {31'd0, req_ready}, 32'd0);
            req_addr = 16'h0100; #1;
            chk("bp_ready_bank1", {31'd0, req_ready}, 32'd1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        drain();

        // Reset mid-operation drops the in-flight request
        do_reset();
        do_req(16'h0000, 4'd11, a);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #1;
            chk("rst_drop_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        do_req(16'h0000, 4'd12, a); push_exp(4'd12, 8'd55, a + 54); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/simmem_bank_delay_calc.md
SIMMEM_BANK_DELAY_CALC -- requirements
Module: simmem_bank_delay_calc

Interface
REQ-001 The block SHALL have parameter NumBanks, default 4, number of independent DRAM banks (power of two, >= 2).
REQ-002 The block SHALL have parameter AddrWidth, default 16, request address width.
REQ-003 The block SHALL have parameter RowBufferLenWidth, default 8, log2 of row-buffer length in bytes.
REQ-004 The block SHALL have parameter IdWidth, default 4, AXI identifier width.
REQ-005 The block SHALL have parameters RowHitCost (default 10, must be >= 3), PrechargeCost (default 50) and ActivationCost (default 45), all in cycles.
REQ-006 The block SHALL have parameter CostWidth, default 8, width of the delay output; it must hold PrechargeCost+ActivationCost+RowHitCost.
REQ-007 The block SHALL have port clk_i, input, 1 bit, the only clock.
REQ-008 The block SHALL have port rst_i, input, 1 bit, reset; synchronous, active-high.
REQ-009 The block SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1), the request handshake.
REQ-010 The block SHALL have ports req_addr_i (input, AddrWidth) and req_id_i (input, IdWidth), the request payload.
REQ-011 The block SHALL have ports resp_valid_o (output, 1) and resp_ready_i (input, 1), the response handshake.
REQ-012 The block SHALL have ports resp_id_o (output, IdWidth) and resp_delay_o (output, CostWidth), the response payload.

Function
REQ-013 The bank index SHALL be req_addr_i[RowBufferLenWidth +: log2(NumBanks)], and the row SHALL be every address bit above that field.
REQ-014 Per bank, the block SHALL hold: occupied flag, stored id, stored cost, countdown counter, open-row register and open-row-valid flag.
REQ-015 req_ready_o SHALL be high iff the addressed bank is not occupied; it SHALL depend on current registered state and req_addr_i only, never on resp_ready_i.
REQ-016 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both high.
REQ-017 Cost SHALL be RowHitCost if open-row-valid is set and the row matches; ActivationCost+RowHitCost if open-row-valid is clear; PrechargeCost+ActivationCost+RowHitCost otherwise.
REQ-018 On acceptance, the bank SHALL set occupied, store id and cost, load its counter with cost-1, set open row to the request row, and set open-row-valid.
REQ-019 While occupied and the counter is nonzero, the counter SHALL decrement by one per cycle.
REQ-020 A bank SHALL be done when occupied and its counter is zero.
REQ-021 For an isolated request accepted at edge t, resp_valid_o SHALL first be high in the cycle starting at edge t+cost-1, i.e. cost cycles after the acceptance cycle.
REQ-022 Among done banks, the block SHALL select by round-robin: the lowest index strictly after the last-granted bank, wrapping modulo NumBanks.
REQ-023 resp_valid_o SHALL be high iff at least one bank is done; resp_id_o and resp_delay_o SHALL carry the selected bank's stored id and cost, and be zero when resp_valid_o is low.
REQ-024 While resp_valid_o is high and resp_ready_i is low, the selection and payload SHALL stay stable.
REQ-025 When resp_valid_o and resp_ready_i are both high on an edge, the selected bank SHALL clear occupied, and the last-granted pointer SHALL update to that bank.
REQ-026 A bank freed on edge t SHALL accept a new request no earlier than edge t+1.
REQ-027 Open-row state SHALL persist after the response and SHALL change only on acceptance or reset.

Reset
REQ-028 While rst_i is high on an edge, the block SHALL clear all occupied flags, open-row-valid flags, counters, stored ids and stored costs.
REQ-029 While rst_i is high on an edge, the block SHALL set the last-granted pointer to NumBanks-1, so bank 0 has first priority.
REQ-030 In-flight requests SHALL be dropped without a response if reset is asserted mid-operation.
REQ-031 After reset, outputs SHALL be: resp_valid_o=0, resp_id_o=0, resp_delay_o=0, req_ready_o=1.

Verification
REQ-032 Cold then hit then miss: addr 0x0000 id 3 -> delay 55, id 3; then 0x0004 id 4 -> delay 10; then 0x0400 id 5 -> delay 105; each response arrives cost cycles after acceptance.
REQ-033 Bank parallelism: 0x0000 id 1, then 0x0100 id 2 in the next cycle -> both delay 55; responses arrive in consecutive cycles, id 1 first.
REQ-034 Round-robin: banks 1 and 2 done in the same cycle with pointer=1 -> bank 2 is granted first, then bank 1.
REQ-035 Backpressure: resp_ready_i held low for 20 cycles after bank 0 is done -> payload stays stable, req_ready_o=0 for bank 0 addresses and 1 for other banks.
REQ-036 Reset mid-operation: rst_i pulsed 30 cycles after accepting 0x0000 -> no response; a following 0x0000 request gives delay 55 (cold).
